// File: rtl/cpu_pkg.sv
// Shared front-end types: issue/instruction widths, opcodes and the register-writer classifier.
// With FETCH_BUFFER_PREDECODE_EN, the fetch buffer entry also carries the predecoded write info.
package cpu_pkg;

    localparam int unsigned ISSUE_WIDTH = 4;
    localparam int unsigned INSTR_W     = 16;
    localparam int unsigned PC_W        = 16;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LEA = 4'b1110;

    // True for opcodes whose result lands in the register named by instr[11:9].
    function automatic logic writes_reg(input logic [3:0] opcode);
        logic wr;
        case (opcode)
            OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDI, OP_LDR, OP_LEA: wr = 1'b1;
            default:                                               wr = 1'b0;
        endcase
        return wr;
    endfunction

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
`ifdef FETCH_BUFFER_PREDECODE_EN
        logic               wr_en;
        logic [2:0]         wr_reg;
`endif
    } fb_entry_t;

endpackage

// File: rtl/fetch_buffer_predecode.sv
// Per-instruction destination predecode, used by fetch_buffer when FETCH_BUFFER_PREDECODE_EN is set.
// Only the opcode and destination field are needed, so only instr[15:9] comes in.
module fetch_buffer_predecode
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:9] instr_hi_i,
    output logic               wr_en_o,
    output logic [2:0]         wr_reg_o
);

    assign wr_en_o  = writes_reg(instr_hi_i[15:12]);
    assign wr_reg_o = wr_en_o ? instr_hi_i[11:9] : 3'd0;

endmodule

// File: rtl/fetch_buffer.sv
// Circular instruction buffer between 4-wide fetch and decode; flushed on redirect.
// Optional FETCH_BUFFER_PREDECODE_EN adds stored per-entry destination predecode outputs.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [2:0]                   in_count,
    input  logic [PC_W-1:0]              in_pc,
    input  logic [ISSUE_WIDTH*INSTR_W-1:0] in_instr,
    output logic                         in_ready,
    output logic [ISSUE_WIDTH-1:0]       out_valid,
    output logic [ISSUE_WIDTH*PC_W-1:0]  out_pc,
    output logic [ISSUE_WIDTH*INSTR_W-1:0] out_instr,
    input  logic [2:0]                   deq_count,
    output logic [CNT_W-1:0]             occupancy
`ifdef FETCH_BUFFER_PREDECODE_EN
    ,
    output logic [ISSUE_WIDTH-1:0]       out_wr_en,
    output logic [ISSUE_WIDTH*3-1:0]     out_wr_reg
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fb_entry_t            mem_q [DEPTH];
    fb_entry_t            in_entry [ISSUE_WIDTH];
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 enq_fire;
    logic [2:0]           enq_n;
    logic [CNT_W-1:0]     deq_ext, deq_eff;

    // Ready looks only at the registered count so fetch never sees a path from decode or flush.
    assign in_ready  = (count_q <= CNT_W'(DEPTH - ISSUE_WIDTH));
    assign occupancy = count_q;

    assign enq_fire = in_valid && in_ready && !flush;
    assign enq_n    = !enq_fire ? 3'd0 : (in_count > 3'd4) ? 3'd4 : in_count;
    assign deq_ext  = CNT_W'(deq_count);
    assign deq_eff  = (deq_ext > count_q) ? count_q : deq_ext;

`ifdef FETCH_BUFFER_PREDECODE_EN
    logic       pd_wr_en  [ISSUE_WIDTH];
    logic [2:0] pd_wr_reg [ISSUE_WIDTH];

    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_pd
        fetch_buffer_predecode u_pd (
            .instr_hi_i (in_instr[(ISSUE_WIDTH-g)*INSTR_W-1 -: 7]),
            .wr_en_o    (pd_wr_en[g]),
            .wr_reg_o   (pd_wr_reg[g])
        );
    end
`endif

    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            in_entry[k]       = '0;
            in_entry[k].pc    = in_pc + PC_W'(2 * k);
            in_entry[k].instr = in_instr[(ISSUE_WIDTH-k)*INSTR_W-1 -: INSTR_W];
`ifdef FETCH_BUFFER_PREDECODE_EN
            in_entry[k].wr_en  = pd_wr_en[k];
            in_entry[k].wr_reg = pd_wr_reg[k];
`endif
        end
    end

    // Storage holds data only; flush and reset just move the pointers.
    always_ff @(posedge clk) begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (3'(k) < enq_n) begin
                mem_q[tail_q + PTR_W'(k)] <= in_entry[k];
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(deq_eff);
            tail_d  = tail_q + PTR_W'(enq_n);
            count_d = count_q + CNT_W'(enq_n) - deq_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        out_valid = '0;
        out_pc    = '0;
        out_instr = '0;
`ifdef FETCH_BUFFER_PREDECODE_EN
        out_wr_en  = '0;
        out_wr_reg = '0;
`endif
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (CNT_W'(k) < count_q) begin
                out_valid[ISSUE_WIDTH-1-k] = 1'b1;
                out_pc[(ISSUE_WIDTH-k)*PC_W-1 -: PC_W] = mem_q[head_q + PTR_W'(k)].pc;
                out_instr[(ISSUE_WIDTH-k)*INSTR_W-1 -: INSTR_W] =
                    mem_q[head_q + PTR_W'(k)].instr;
`ifdef FETCH_BUFFER_PREDECODE_EN
                out_wr_en[ISSUE_WIDTH-1-k] = mem_q[head_q + PTR_W'(k)].wr_en;
                out_wr_reg[(ISSUE_WIDTH-k)*3-1 -: 3] = mem_q[head_q + PTR_W'(k)].wr_reg;
`endif
            end
        end
    end

endmodule
